// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, none/even/odd/mark parity,
// one or two stop bits, line-break generator, valid/ready word intake.
module uart_tx_cfg #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  input  logic                 tx_break,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned      CNT_W     = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_e;

  state_e               state_q,    state_d;
  logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_cnt_q,  bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic [1:0]           parity_q,   parity_d;
  logic                 stop2_q,    stop2_d;
  logic                 data_xor_q, data_xor_d;
  logic                 tx_q,       tx_d;
  logic                 ready_q,    ready_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;

  logic                 bit_end;
  logic                 parity_bit;

  always_comb begin
    bit_end = baud_tick && (tick_cnt_q == TICK_LAST);
    case (parity_q)
      2'b01:   parity_bit = data_xor_q;
      2'b10:   parity_bit = ~data_xor_q;
      default: parity_bit = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    stop2_d    = stop2_q;
    data_xor_d = data_xor_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Shared bit-period counter; the ending tick also opens the next bit.
    if (baud_tick && (state_q inside {START, DATA, PARITY, STOP}))
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (tx_break) begin
          state_d = BREAK;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end else if (tx_valid && ready_q) begin
          shift_d    = tx_data;
          parity_d   = cfg_parity;
          stop2_d    = cfg_stop2;
          data_xor_d = ^tx_data;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (baud_tick) begin
          tx_d       = 1'b0;
          tick_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            if (parity_q != 2'b00) begin
              tx_d    = parity_bit;
              state_d = PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            tx_d    = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      BREAK: begin
        tx_d    = 1'b0;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        if (baud_tick && !tx_break) begin
          tx_d    = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= '0;
      stop2_q    <= 1'b0;
      data_xor_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      stop2_q    <= stop2_d;
      data_xor_q <= data_xor_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule
